// File: rtl/aes_block_sequencer_if.sv
// Bus bundle between the block sequencer and its surroundings.
// Carries the job request from the register file (start, abort, byte_size, key),
// the source buffer read port (src_rd_en, src_addr, src_rd_data), the AES core
// handshake (st_aes, aes_key, plain_text, aes_done, cp_text), the destination
// buffer write port (dst_wr_en, dst_addr, dst_wr_data) and job status
// (busy, done, blk_cnt).
// master: the sequencer side; slave: register file / core / buffer side.
interface aes_block_sequencer_if #(
    parameter int BUF_AW = 7,
    parameter int CNT_W  = 12
);
    logic              start;
    logic              abort;
    logic [15:0]       byte_size;
    logic [127:0]      key;
    logic              src_rd_en;
    logic [BUF_AW-1:0] src_addr;
    logic [31:0]       src_rd_data;
    logic              st_aes;
    logic [127:0]      aes_key;
    logic [127:0]      plain_text;
    logic              aes_done;
    logic [127:0]      cp_text;
    logic              dst_wr_en;
    logic [BUF_AW-1:0] dst_addr;
    logic [31:0]       dst_wr_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  blk_cnt;

    modport master (
        input  start, abort, byte_size, key, src_rd_data, aes_done, cp_text,
        output src_rd_en, src_addr, st_aes, aes_key, plain_text,
               dst_wr_en, dst_addr, dst_wr_data, busy, done, blk_cnt
    );

    modport slave (
        output start, abort, byte_size, key, src_rd_data, aes_done, cp_text,
        input  src_rd_en, src_addr, st_aes, aes_key, plain_text,
               dst_wr_en, dst_addr, dst_wr_data, busy, done, blk_cnt
    );
endinterface

// File: rtl/aes_block_sequencer.sv
// Drives the AES core over a multi-block buffer: reads four 32-bit source words,
// packs them into a 128-bit block, runs the core, then writes the ciphertext
// back as four words. Repeats for byte_size[15:4] blocks and pulses done.
// Ports:
//   clk  - clock, all logic on the rising edge
//   rst  - asynchronous active-high reset
//   bus  - aes_block_sequencer_if.master (job control, source read port,
//          AES core handshake, destination write port, status)
module aes_block_sequencer #(
    parameter int BUF_AW = 7,
    parameter int CNT_W  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_block_sequencer_if.master bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] CAP   = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] WR    = 3'd5;
    localparam logic [2:0] CHK   = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    // Byte order of a buffer word is the reverse of the block byte order.
    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [2:0]       state_reg, state_next;
    logic [1:0]       k_reg;
    logic [CNT_W-1:0] blk_reg, nblk_reg, blk_cnt_reg;
    logic [CNT_W-1:0] blk_inc, nblk_in;
    logic [127:0]     key_reg, pt_reg, ct_reg;
    logic [31:0]      rd_word;
    logic [31:0]      ct_word [4];
    logic             rd_en, wr_en, abort_hit;
    logic             unused_low_bits;

    assign nblk_in         = CNT_W'(bus.byte_size[15:4]);
    assign unused_low_bits = ^bus.byte_size[3:0];
    assign blk_inc         = blk_reg + CNT_W'(1);
    assign rd_word         = bswap(bus.src_rd_data);
    assign abort_hit       = bus.abort && (state_reg != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ct_word
            assign ct_word[gi] = bswap(ct_reg[127-32*gi -: 32]);
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        if (abort_hit) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (bus.start) state_next = (nblk_in != '0) ? RD : DONE;
                RD:      if (k_reg == 2'd3) state_next = CAP;
                CAP:     state_next = START;
                START:   state_next = WAIT;
                WAIT:    if (bus.aes_done) state_next = WR;
                WR:      if (k_reg == 2'd3) state_next = CHK;
                CHK:     state_next = (blk_inc == nblk_reg) ? DONE : RD;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            k_reg       <= 2'd0;
            blk_reg     <= '0;
            nblk_reg    <= '0;
            blk_cnt_reg <= '0;
            key_reg     <= '0;
            pt_reg      <= '0;
            ct_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (abort_hit) begin
                // Partial block count and registers are left as they are.
                k_reg <= 2'd0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start) begin
                            key_reg     <= bus.key;
                            nblk_reg    <= nblk_in;
                            blk_reg     <= '0;
                            blk_cnt_reg <= '0;
                            k_reg       <= 2'd0;
                        end
                    end
                    RD: begin
                        // Read data lags the address by one cycle, so the
                        // word read at k-1 is captured while issuing read k.
                        k_reg <= k_reg + 2'd1;
                        case (k_reg)
                            2'd1:    pt_reg[127:96] <= rd_word;
                            2'd2:    pt_reg[95:64]  <= rd_word;
                            2'd3:    pt_reg[63:32]  <= rd_word;
                            default: ;
                        endcase
                    end
                    CAP:  pt_reg[31:0] <= rd_word;
                    WAIT: if (bus.aes_done) ct_reg <= bus.cp_text;
                    WR:   k_reg <= k_reg + 2'd1;
                    CHK: begin
                        blk_reg     <= blk_inc;
                        blk_cnt_reg <= blk_cnt_reg + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_en = (state_reg == RD);
    assign wr_en = (state_reg == WR);

    // Word address is 4*blk + k, wrapping modulo the buffer size.
    assign bus.src_rd_en   = rd_en;
    assign bus.src_addr    = rd_en ? BUF_AW'({blk_reg, k_reg}) : '0;
    assign bus.dst_wr_en   = wr_en;
    assign bus.dst_addr    = wr_en ? BUF_AW'({blk_reg, k_reg}) : '0;
    assign bus.dst_wr_data = wr_en ? ct_word[k_reg] : '0;
    assign bus.st_aes      = (state_reg == START);
    assign bus.aes_key     = key_reg;
    assign bus.plain_text  = pt_reg;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.done        = (state_reg == DONE);
    assign bus.blk_cnt     = blk_cnt_reg;
endmodule
